// File: rtl/amdc_leds_frame_sequencer_if.sv
// Register-side bundle for the LED frame sequencer: colour snapshot source,
// request/enable controls and the serial line plus status back out.
interface amdc_leds_frame_sequencer_if #(
  parameter int NUM_LEDS = 4
);
  logic                     enable;
  logic [NUM_LEDS*24-1:0]   color_in;
  logic                     update_req;
  logic                     led_dout;
  logic                     busy;
  logic                     frame_done;
  logic [15:0]              frame_count;

  modport master (
    output enable, color_in, update_req,
    input  led_dout, busy, frame_done, frame_count
  );

  modport slave (
    input  enable, color_in, update_req,
    output led_dout, busy, frame_done, frame_count
  );
endinterface

// File: rtl/amdc_leds_frame_sequencer.sv
// WS2812-style NRZ serializer: snapshots all GRB words at frame start, shifts
// them out MSB first (LED0 first), then holds the line low for the latch time.
module amdc_leds_frame_sequencer #(
  parameter int NUM_LEDS       = 4,
  parameter int T_BIT          = 125,
  parameter int T0_HIGH        = 40,
  parameter int T1_HIGH        = 80,
  parameter int T_LATCH        = 8000,
  parameter int REFRESH_CYCLES = 0
) (
  input logic ACLK,
  input logic ARESET,
  amdc_leds_frame_sequencer_if.slave bus
);

  localparam int M1   = (T_BIT > T_LATCH) ? T_BIT : T_LATCH;
  localparam int MAXC = (M1 > REFRESH_CYCLES) ? M1 : REFRESH_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int LW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int BW   = NUM_LEDS * 24;

  localparam logic [CW-1:0] C_T0   = CW'(T0_HIGH - 1);
  localparam logic [CW-1:0] C_T1   = CW'(T1_HIGH - 1);
  localparam logic [CW-1:0] C_BIT  = CW'(T_BIT - 1);
  localparam logic [CW-1:0] C_LAT  = CW'(T_LATCH - 1);
  localparam logic [CW-1:0] C_LAT2 = CW'((T_LATCH > 1) ? T_LATCH - 2 : 0);
  localparam logic [CW-1:0] C_REF  = CW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
  localparam logic [LW-1:0] LAST_LED = LW'(NUM_LEDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BIT_HIGH, S_BIT_LOW, S_LATCH} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_tmr;
  logic [BW-1:0]   r_buf;
  logic [23:0]     r_word;
  logic [4:0]      r_bit;
  logic [LW-1:0]   r_led;
  logic            r_pending;
  logic            r_dout;
  logic            r_busy;
  logic            r_done;
  logic [15:0]     r_count;

  logic            w_tick;
  logic            w_start_req;
  logic            w_launch;
  logic [CW-1:0]   w_hi_end;
  logic [BW-1:0]   w_next_buf;

  assign w_tick      = bus.enable && (REFRESH_CYCLES > 0) && (r_tmr == C_REF);
  assign w_start_req = bus.update_req || w_tick;
  assign w_launch    = (r_state == S_IDLE) && bus.enable && (r_pending || w_start_req);
  assign w_hi_end    = r_word[23] ? C_T1 : C_T0;
  assign w_next_buf  = r_buf >> 24;

  // Refresh timer runs frame-start to frame-start, independent of busy.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                                   r_tmr <= '0;
    else if (!bus.enable || REFRESH_CYCLES == 0)  r_tmr <= '0;
    else if (r_tmr == C_REF)                      r_tmr <= '0;
    else                                          r_tmr <= r_tmr + 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_buf     <= '0;
      r_word    <= '0;
      r_bit     <= '0;
      r_led     <= '0;
      r_pending <= 1'b0;
      r_dout    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
    end else begin
      r_done <= 1'b0;
      // Requests arriving while a frame cannot start collapse into one.
      if (w_launch)         r_pending <= 1'b0;
      else if (w_start_req) r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_buf   <= bus.color_in;
          r_word  <= bus.color_in[23:0];
          r_bit   <= 5'd23;
          r_led   <= '0;
          r_cnt   <= '0;
          r_dout  <= 1'b1;
          r_state <= S_BIT_HIGH;
        end
        S_BIT_HIGH: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == w_hi_end) begin
            r_dout  <= 1'b0;
            r_state <= S_BIT_LOW;
          end
        end
        S_BIT_LOW: begin
          if (r_cnt == C_BIT) begin
            r_cnt <= '0;
            if (r_bit != 5'd0) begin
              r_bit   <= r_bit - 5'd1;
              r_word  <= r_word << 1;
              r_dout  <= 1'b1;
              r_state <= S_BIT_HIGH;
            end else if (r_led != LAST_LED) begin
              r_bit   <= 5'd23;
              r_led   <= r_led + 1'b1;
              r_buf   <= w_next_buf;
              r_word  <= w_next_buf[23:0];
              r_dout  <= 1'b1;
              r_state <= S_BIT_HIGH;
            end else begin
              r_state <= S_LATCH;
              r_done  <= (T_LATCH == 1);
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          if (r_cnt == C_LAT) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_count <= r_count + 16'd1;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            // Registered pulse lands exactly on the last latch cycle.
            r_done <= (T_LATCH > 1) && (r_cnt == C_LAT2);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.led_dout    = r_dout;
  assign bus.busy        = r_busy;
  assign bus.frame_done  = r_done;
  assign bus.frame_count = r_count;

endmodule

// File: tb/tb_amdc_leds_frame_sequencer.sv
// Bench for the LED frame sequencer: table-driven frames, random colours vs a
// cycle-level waveform model, plus snapshot/pending/refresh/reset/enable cases.
module tb_amdc_leds_frame_sequencer;
  localparam int NL   = 2;
  localparam int TBIT = 10;
  localparam int T0   = 3;
  localparam int T1   = 7;
  localparam int TL   = 20;
  localparam int FL   = 1 + NL*24*TBIT + TL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  amdc_leds_frame_sequencer_if #(.NUM_LEDS(NL)) ifc();
  amdc_leds_frame_sequencer_if #(.NUM_LEDS(NL)) ifr();

  amdc_leds_frame_sequencer #(
    .NUM_LEDS(NL), .T_BIT(TBIT), .T0_HIGH(T0), .T1_HIGH(T1),
    .T_LATCH(TL), .REFRESH_CYCLES(0)
  ) u_dut (.ACLK(clk), .ARESET(rst), .bus(ifc));

  amdc_leds_frame_sequencer #(
    .NUM_LEDS(NL), .T_BIT(TBIT), .T0_HIGH(T0), .T1_HIGH(T1),
    .T_LATCH(TL), .REFRESH_CYCLES(600)
  ) u_dut_r (.ACLK(clk), .ARESET(rst), .bus(ifr));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Line level at frame cycle k (k=0 is the LOAD cycle).
  function automatic logic exp_dout(input logic [47:0] col, input int k);
    int j, pos, led, b, hi;
    logic [47:0] s;
    if (k < 1 || k > NL*24*TBIT) return 1'b0;
    j   = (k - 1) / TBIT;
    pos = (k - 1) % TBIT;
    led = j / 24;
    b   = 23 - (j % 24);
    s   = col >> (led*24 + b);
    hi  = s[0] ? T1 : T0;
    return (pos < hi);
  endfunction

  typedef struct {
    logic [47:0] col;
    int          nlong;
    int          nshort;
  } vec_t;
  vec_t vt[5];

  // Leaves the caller at the falling edge inside the LOAD cycle.
  task automatic kick();
    @(negedge clk); ifc.update_req = 1'b1;
    @(negedge clk); ifc.update_req = 1'b0;
  endtask

  // Called at the LOAD-cycle negedge; returns at the first post-frame negedge.
  task automatic capture(input logic [47:0] col, input bit extra, input bit chg,
                         input logic [47:0] chg_col, input string nm,
                         output int nlong, output int nshort);
    int bad_k = -1, busy_bad = -1, ndone = 0, done_at = -1, run = 0, nodd = 0;
    nlong = 0; nshort = 0;
    for (int k = 0; k < FL; k++) begin
      if (k > 0) @(negedge clk);
      if (ifc.led_dout !== exp_dout(col, k) && bad_k < 0) bad_k = k;
      if (ifc.busy !== 1'b1 && busy_bad < 0) busy_bad = k;
      if (ifc.frame_done === 1'b1) begin ndone++; done_at = k; end
      if (ifc.led_dout === 1'b1) run++;
      else if (run > 0) begin
        if (run == T1) nlong++; else if (run == T0) nshort++; else nodd++;
        run = 0;
      end
      if (extra) ifc.update_req = (k == 50 || k == 100 || k == 200);
      if (chg && k == 2) ifc.color_in = chg_col;
    end
    ifc.update_req = 1'b0;
    chk({nm, "_wave_first_bad"}, bad_k, -1);
    chk({nm, "_busy_first_low"}, busy_bad, -1);
    chk({nm, "_done_pulses"}, ndone, 1);
    chk({nm, "_done_cycle"}, done_at, FL - 1);
    chk({nm, "_odd_pulses"}, nodd, 0);
    @(negedge clk);
    chk({nm, "_busy_after"}, ifc.busy, 0);
    chk({nm, "_done_after"}, ifc.frame_done, 0);
  endtask

  initial begin
    int nl, ns, cnt, nrise, hits;
    int rise_at[8];
    logic prev;
    logic [47:0] col;

    vt[0] = '{{24'h000001, 24'hFF0000},  9, 39};
    vt[1] = '{{24'h000000, 24'h000000},  0, 48};
    vt[2] = '{{24'hFFFFFF, 24'hFFFFFF}, 48,  0};
    vt[3] = '{{24'h800000, 24'h00FF00},  9, 39};
    vt[4] = '{{24'h5A5A5A, 24'hA5A5A5}, 24, 24};

    ifc.enable = 1'b1; ifc.update_req = 1'b0; ifc.color_in = '0;
    ifr.enable = 1'b0; ifr.update_req = 1'b0; ifr.color_in = {$urandom, $urandom};

    repeat (3) @(negedge clk);
    chk("rst_dout", ifc.led_dout, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.frame_done, 0);
    chk("rst_count", ifc.frame_count, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", ifc.busy, 0);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      ifc.color_in = vt[i].col;
      kick();
      capture(vt[i].col, 0, 0, '0, $sformatf("vec%0d", i), nl, ns);
      chk($sformatf("vec%0d_long", i), nl, vt[i].nlong);
      chk($sformatf("vec%0d_short", i), ns, vt[i].nshort);
      chk($sformatf("vec%0d_count", i), ifc.frame_count, i + 1);
    end
    cnt = 5;

    // Snapshot: colour changes two cycles after LOAD must not leak in
    col = {24'h000001, 24'hFF0000};
    ifc.color_in = col;
    kick();
    capture(col, 0, 1, {24'h000001, 24'h00FF00}, "snap_old", nl, ns);
    kick();
    capture({24'h000001, 24'h00FF00}, 0, 0, '0, "snap_new", nl, ns);
    cnt += 2;
    chk("snap_count", ifc.frame_count, cnt);

    // Pending collapse: three requests mid-frame give exactly one more frame
    col = {24'h123456, 24'h89ABCD};
    ifc.color_in = col;
    kick();
    capture(col, 1, 0, '0, "pend_a", nl, ns);
    @(negedge clk);
    chk("pend_reload_busy", ifc.busy, 1);
    capture(col, 0, 0, '0, "pend_b", nl, ns);
    cnt += 2;
    hits = 0;
    repeat (600) begin
      @(negedge clk);
      if (ifc.busy === 1'b1) hits++;
    end
    chk("pend_no_third", hits, 0);
    chk("pend_count", ifc.frame_count, cnt);

    // Random colours against the waveform model
    for (int i = 0; i < 6; i++) begin
      col = {$urandom, $urandom};
      ifc.color_in = col;
      kick();
      capture(col, 0, 0, '0, $sformatf("rnd%0d", i), nl, ns);
      chk($sformatf("rnd%0d_bits", i), nl + ns, 48);
      cnt++;
      chk($sformatf("rnd%0d_count", i), ifc.frame_count, cnt);
    end

    // Disabled request is held until enable returns
    ifc.enable = 1'b0;
    kick();
    hits = 0;
    repeat (30) begin
      @(negedge clk);
      if (ifc.busy === 1'b1 || ifc.led_dout === 1'b1) hits++;
    end
    chk("dis_quiet", hits, 0);
    col = {24'h0F0F0F, 24'hF0F0F0};
    ifc.color_in = col;
    ifc.enable = 1'b1;
    @(negedge clk);
    capture(col, 0, 0, '0, "dis_held", nl, ns);
    cnt++;
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (ifc.busy === 1'b1) hits++;
    end
    chk("dis_single", hits, 0);
    chk("dis_count", ifc.frame_count, cnt);

    // Auto-refresh on the second instance
    nrise = 0; prev = 1'b0;
    ifr.enable = 1'b1;
    for (int c = 1; c <= 4200; c++) begin
      @(negedge clk);
      if (ifr.busy === 1'b1 && prev === 1'b0) begin
        if (nrise < 8) rise_at[nrise] = c;
        nrise++;
      end
      prev = ifr.busy;
      if (c == 2350) chk("ref_count_3", ifr.frame_count, 3);
      if (c == 2410) ifr.enable = 1'b0;
    end
    chk("ref_rises", nrise, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ref_load%0d", i), (i < nrise) ? rise_at[i] : -1, 600*(i+1));
    chk("ref_final_count", ifr.frame_count, 4);
    chk("ref_final_busy", ifr.busy, 0);

    // Reset during BIT_HIGH clears outputs without a clock edge
    ifc.color_in = {24'h000000, 24'hFF0000};
    kick();
    @(negedge clk);
    @(negedge clk);
    chk("mid_pre_dout", ifc.led_dout, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_dout", ifc.led_dout, 0);
    chk("mid_rst_busy", ifc.busy, 0);
    chk("mid_rst_count", ifc.frame_count, 0);
    chk("mid_rst_count_r", ifr.frame_count, 0);
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (ifc.busy === 1'b1 || ifc.led_dout === 1'b1 || ifc.frame_done === 1'b1) hits++;
    end
    chk("post_rst_idle", hits, 0);
    col = {24'hC3C3C3, 24'h3C3C3C};
    ifc.color_in = col;
    kick();
    capture(col, 0, 0, '0, "post_rst", nl, ns);
    chk("post_rst_count", ifc.frame_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
